decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  instruction word present.
REQ-005 in_instr  input  32  fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0].
REQ-006 in_ready  output  1  stage accepts in_instr this cycle.
REQ-007 ra1 / ra2  output  5  register-file read addresses; combinational from in_instr (rs / rt).
REQ-008 rd1 / rd2  input  32  register-file read data for ra1 / ra2; combinational, same cycle.
REQ-009 wb_we / wb_wa / wb_wd  input  1 / 5 / 32  writeback port, same signals that drive regfile we3 / wa3 / wd3.
REQ-010 ex_valid  output  1  ID/EX register holds a valid op.
REQ-011 ex_ready  input  1  downstream consumes ex_* this cycle.
REQ-012 ex_a / ex_b  output  32  source operands.
REQ-013 ex_imm  output  32  sign-extended imm.
REQ-014 ex_op / ex_funct  output  6 / 6  opcode and funct fields.
REQ-015 ex_we / ex_wa  output  1 / 5  destination write enable and address.

Function
REQ-016 R-type (op==0): sources rs, rt; destination rd. Any other op: source rs only; destination rt; ex_b = rd2 (store data).
REQ-017 ex_we SHALL be 0 when the destination is register 0; ex_wa is still carried.
REQ-018 Scoreboard: 32 busy bits; bit 0 always 0.
REQ-019 Issue (in_valid && in_ready) with ex_we=1 SHALL set busy[dest] at the next edge.
REQ-020 wb_we=1 with wb_wa!=0 SHALL clear busy[wb_wa] at the next edge.
REQ-021 Set and clear of the same register on one edge: set wins.
REQ-022 Hazard = any used source with busy=1 and no bypass available (REQ-032). Register 0 is never a hazard.
REQ-023 in_ready = !hazard && (!ex_valid || ex_ready).
REQ-024 ID/EX register:
- loads on issue;
- holds all ex_* while ex_valid && !ex_ready;
- clears ex_valid when ex_ready is high and there is no issue.
REQ-025 Latency: one cycle from issue to ex_valid.
REQ-026 Throughput: one instruction per cycle when no hazard and ex_ready=1.
REQ-027 in_valid=0 SHALL NOT change the scoreboard or the ID/EX register except the ex_valid clear in REQ-024.
REQ-028 ex_a / ex_b are taken from rd1 / rd2 unless a bypass applies (REQ-032).

Reset
REQ-029 While reset is high:
- ex_valid=0, ex_we=0;
- all busy bits 0;
- ex_a, ex_b, ex_imm, ex_op, ex_funct, ex_wa = 0.
REQ-030 Reset asserted mid-stall SHALL discard the held op. The first instruction after release SHALL issue with no hazard.

Configuration
REQ-031 Macro DECODE_BYPASS_EN controls same-cycle writeback bypass.
REQ-032 With DECODE_BYPASS_EN defined, a source matching wb_wa with wb_we=1 and wb_wa!=0 SHALL:
- take wb_wd instead of rd1 / rd2;
- not count as a hazard.
REQ-033 Without DECODE_BYPASS_EN, that source SHALL stall for one cycle. It issues on the next cycle from the regfile value.

Structure
REQ-034 Package decode_pkg SHALL hold:
- instr_t: packed struct of the instruction fields;
- OP_RTYPE = 6'd0;
- NUM_REGS = 32.
REQ-035 Sub-module scoreboard SHALL hold the busy bits, the set/clear logic and the per-source busy lookup.

Verification
REQ-036 Reset, then issue op=0 rs=2 rt=3 rd=4 with rd1=12, rd2=5, ex_ready=1 -> next cycle ex_valid=1, ex_a=12, ex_b=5, ex_we=1, ex_wa=4; busy[4]=1.
REQ-037 Next instruction reads rs=4 while busy[4]=1 and no writeback -> in_ready=0. Then wb_we=1, wb_wa=4, wb_wd=7:
- with DECODE_BYPASS_EN: issues that cycle with ex_a=7;
- without it: issues one cycle later with ex_a=rd1.
REQ-038 I-type op=8 rs=0 rt=0 imm=16'hFFFF -> ex_we=0, ex_imm=32'hFFFFFFFF, no busy bit set, no stall on register 0.
REQ-039 Hold ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, in_ready=0. Then ex_ready=1 with a new in_valid -> back-to-back issue.
REQ-040 Issue dest=5 on the same edge as wb_we=1, wb_wa=5 -> busy[5]=1 after the edge.
REQ-041 Assert reset while stalled with ex_valid=1 -> ex_valid=0 and all busy=0 immediately; after release, rs=5 issues without a stall.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode stage.
package decode_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              we;
    logic [REG_AW-1:0] wa;
  } idex_t;

  // The immediate occupies rd/shamt/funct, i.e. the low 16 instruction bits.
  function automatic logic [DATA_W-1:0] sext_imm(input instr_t ins);
    return {{16{ins.rd[4]}}, ins.rd, ins.shamt, ins.funct};
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy-bit scoreboard: set on issue, cleared on writeback, set wins.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  input  logic [REG_AW-1:0] src1_addr_i,
  input  logic [REG_AW-1:0] src2_addr_i,
  output logic              src1_busy_o,
  output logic              src2_busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i && (clr_addr_i != '0)) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign src1_busy_o = busy_q[src1_addr_i];
  assign src2_busy_o = busy_q[src2_addr_i];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with operand read, hazard stall and ID/EX register.
// Build option: define DECODE_BYPASS_EN for same-cycle writeback bypass.
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [5:0]        ex_op,
  output logic [5:0]        ex_funct,
  output logic              ex_we,
  output logic [REG_AW-1:0] ex_wa
);

  instr_t            ins;
  logic              is_rtype;
  logic [REG_AW-1:0] dest;
  logic              dest_we;
  logic              wb_hit;
  logic              byp_a;
  logic              byp_b;
  logic              src1_busy;
  logic              src2_busy;
  logic              hazard;
  logic              issue;

  logic  ex_valid_q, ex_valid_d;
  idex_t ex_q, ex_d;

  assign ins      = instr_t'(in_instr);
  assign ra1      = ins.rs;
  assign ra2      = ins.rt;
  assign is_rtype = (ins.op == OP_RTYPE);
  assign dest     = is_rtype ? ins.rd : ins.rt;
  assign dest_we  = (dest != '0);
  assign wb_hit   = wb_we && (wb_wa != '0);

`ifdef DECODE_BYPASS_EN
  assign byp_a = wb_hit && (wb_wa == ins.rs);
  assign byp_b = wb_hit && is_rtype && (wb_wa == ins.rt);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  decode_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .set_en_i    (issue && dest_we),
    .set_addr_i  (dest),
    .clr_en_i    (wb_hit),
    .clr_addr_i  (wb_wa),
    .src1_addr_i (ins.rs),
    .src2_addr_i (ins.rt),
    .src1_busy_o (src1_busy),
    .src2_busy_o (src2_busy)
  );

  // rt is only a source for R-type; other ops carry it as the destination.
  assign hazard   = (src1_busy && !byp_a) || (is_rtype && src2_busy && !byp_b);
  assign in_ready = !hazard && (!ex_valid_q || ex_ready);
  assign issue    = in_valid && in_ready;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_d.a     = byp_a ? wb_wd : rd1;
      ex_d.b     = byp_b ? wb_wd : rd2;
      ex_d.imm   = sext_imm(ins);
      ex_d.op    = ins.op;
      ex_d.funct = ins.funct;
      ex_d.we    = dest_we;
      ex_d.wa    = dest;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_a     = ex_q.a;
  assign ex_b     = ex_q.b;
  assign ex_imm   = ex_q.imm;
  assign ex_op    = ex_q.op;
  assign ex_funct = ex_q.funct;
  assign ex_we    = ex_q.we;
  assign ex_wa    = ex_q.wa;

endmodule
